// File: rtl/hazard_controller_pkg.sv
// Shared CPU definitions used by the hazard controller and its helpers.
//   - state_t   : hazard FSM state encoding
//   - FWD_*     : execute-stage operand mux select codes
//   - REG_AW    : register address width
package hazard_controller_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_sel.sv
// Forwarding select for one execute-stage operand (purely combinational).
// Ports:
//   rsE        in  source register read by the execute instruction
//   rdM        in  memory-stage destination register
//   regwriteM  in  memory-stage write enable
//   rdW        in  writeback destination register
//   regwriteW  in  writeback write enable
//   fwd        out mux select: FWD_MEM, FWD_WB or FWD_RF
module forward_sel
    import hazard_controller_pkg::*;
(
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              regwriteM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteW,
    output logic [1:0]        fwd
);

    // The memory stage holds the younger result, so it wins over writeback.
    // R0 is an ordinary register, so address 0 is forwarded like any other.
    always_comb begin
        fwd = FWD_RF;
        if (regwriteM && (rdM == rsE))
            fwd = FWD_MEM;
        else if (regwriteW && (rdW == rsE))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the five-stage CPU. Generates stall,
// flush and forwarding controls for load-use bubbles, control redirects and
// multi-cycle execute operations.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   rs1D/rs2D, useRs1D/useRs2D   decode-stage sources and their use flags
//   rs1E/rs2E, rdE               execute-stage sources and destination
//   regwriteE, resultsrcE        execute write enable / load flag
//   rdM/regwriteM, rdW/regwriteW memory and writeback destinations
//   branch_takenE, jumpE         execute-stage redirect sources
//   mc_startE, mc_doneE          multi-cycle op start / completion
//   stallF/stallD/stallE         hold PC / decode / execute registers
//   flushD/flushE                clear decode / execute registers
//   fwdAE/fwdBE                  execute operand mux selects
//   mc_timeout                   sticky multi-cycle timeout flag
//   busy                         FSM is not in RUN
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic              useRs1D,
    input  logic              useRs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              regwriteE,
    input  logic              resultsrcE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              regwriteM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteW,
    input  logic              branch_takenE,
    input  logic [1:0]        jumpE,
    input  logic              mc_startE,
    input  logic              mc_doneE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic              mc_timeout,
    output logic              busy
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [4:0] MC_LIMIT     = 5'(MC_TIMEOUT);

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;
    logic [4:0] mc_cnt, mc_cnt_next;
    logic       timeout_q, timeout_next;

    logic [1:0] fwd_a, fwd_b;
    logic       redirect, loaduse;

    forward_sel u_fwd_a (
        .rsE       (rs1E),
        .rdM       (rdM),
        .regwriteM (regwriteM),
        .rdW       (rdW),
        .regwriteW (regwriteW),
        .fwd       (fwd_a)
    );

    forward_sel u_fwd_b (
        .rsE       (rs2E),
        .rdM       (rdM),
        .regwriteM (regwriteM),
        .rdW       (rdW),
        .regwriteW (regwriteW),
        .fwd       (fwd_b)
    );

    assign redirect = branch_takenE || (jumpE != 2'b00);
    assign loaduse  = regwriteE && resultsrcE &&
                      ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
            mc_cnt    <= 5'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            mc_cnt    <= mc_cnt_next;
            timeout_q <= timeout_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        mc_cnt_next    = mc_cnt;
        timeout_next   = timeout_q;
        case (state)
            RUN: begin
                // A redirect and mc_startE together cannot be legal; the
                // redirect wins and the multi-cycle start is dropped.
                if (redirect) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_RELOAD;
                    end
                end else if (mc_startE && !mc_doneE) begin
                    state_next  = MC_WAIT;
                    mc_cnt_next = 5'd1;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (flush_cnt <= 3'd1) begin
                    state_next     = RUN;
                    flush_cnt_next = 3'd0;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            MC_WAIT: begin
                if (mc_doneE) begin
                    state_next  = RUN;
                    mc_cnt_next = 5'd0;
                end else if (mc_cnt == MC_LIMIT) begin
                    state_next   = RUN;
                    mc_cnt_next  = 5'd0;
                    timeout_next = 1'b1;
                end else begin
                    mc_cnt_next = mc_cnt + 5'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output logic; everything is forced low while reset is held.
    always_comb begin
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        fwdAE      = FWD_RF;
        fwdBE      = FWD_RF;
        mc_timeout = 1'b0;
        busy       = 1'b0;
        if (rst) begin
            fwdAE      = fwd_a;
            fwdBE      = fwd_b;
            mc_timeout = timeout_q;
            busy       = (state != RUN);
            case (state)
                RUN: begin
                    if (redirect) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (mc_startE) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                    end else if (loaduse) begin
                        // One bubble; the hazard clears once the load reaches M.
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end
                FLUSH: begin
                    flushD = 1'b1;
                    flushE = redirect;
                end
                MC_WAIT: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
